// File: rtl/lh_stream_buffer_if.sv
// Producer/consumer handshake bundle for lh_stream_buffer.
// slave = buffer side, master = the environment driving it.
interface lh_stream_buffer_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] In1_DATA;
  logic              In1_SEND;
  logic [15:0]       In1_COUNT;
  logic              In1_ACK;
  logic [DATA_W-1:0] Out1_DATA;
  logic              Out1_SEND;
  logic              Out1_RDY;
  logic              Out1_ACK;
  logic [15:0]       Out1_COUNT;
  logic [LW-1:0]     LEVEL;

  modport slave (
    input  In1_DATA, In1_SEND, In1_COUNT, Out1_RDY, Out1_ACK,
    output In1_ACK, Out1_DATA, Out1_SEND, Out1_COUNT, LEVEL
  );

  modport master (
    output In1_DATA, In1_SEND, In1_COUNT, Out1_RDY, Out1_ACK,
    input  In1_ACK, Out1_DATA, Out1_SEND, Out1_COUNT, LEVEL
  );
endinterface

// File: rtl/lh_stream_buffer.sv
// FIFO token buffer with arithmetic right-shift on entry and a 2-cycle start-up guard.
// Optional LH_STREAM_BUFFER_CLIP_EN: negative processed tokens are stored as 0.
module lh_stream_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int SHIFT  = 0
) (
  input logic              CLK,
  input logic              RESET,
  lh_stream_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {GUARD_0, GUARD_1, RUN} guard_state_e;

  guard_state_e             state;
  logic                     guard;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [LW-1:0]            level;
  logic                     wr_en;
  logic                     rd_en;
  logic signed [DATA_W-1:0] shifted;
  logic [DATA_W-1:0]        proc;
  logic                     unused_inputs;

  assign shifted = $signed(bus.In1_DATA) >>> SHIFT;

`ifdef LH_STREAM_BUFFER_CLIP_EN
  assign proc = shifted[DATA_W-1] ? '0 : shifted;
`else
  assign proc = shifted;
`endif

  // Full refuses input even when a read happens in the same cycle.
  assign wr_en = guard & bus.In1_SEND & (level < FULL_LVL);
  assign rd_en = guard & bus.Out1_RDY & (level != '0);

  assign bus.In1_ACK    = wr_en;
  assign bus.Out1_SEND  = rd_en;
  assign bus.Out1_DATA  = (level != '0) ? mem[rd_ptr] : '0;
  assign bus.Out1_COUNT = 16'h1;
  assign bus.LEVEL      = level;

  assign unused_inputs = ^{bus.In1_COUNT, bus.Out1_ACK};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= GUARD_0;
      guard  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      case (state)
        GUARD_0: state <= GUARD_1;
        GUARD_1: begin
          state <= RUN;
          guard <= 1'b1;
        end
        default: state <= RUN;
      endcase

      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);

      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; LEVEL and pointers alone define valid contents.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= proc;
  end
endmodule

// File: tb/tb_lh_stream_buffer.sv
// Directed + randomized-handshake bench for lh_stream_buffer (DEPTH=4, SHIFT=0 and SHIFT=2 instances).
module tb_lh_stream_buffer;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CLK = ~CLK;

  lh_stream_buffer_if #(.DATA_W(16), .DEPTH(4)) bus ();
  lh_stream_buffer_if #(.DATA_W(16), .DEPTH(4)) bus2 ();

  lh_stream_buffer #(.DATA_W(16), .DEPTH(4), .SHIFT(0)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  lh_stream_buffer #(.DATA_W(16), .DEPTH(4), .SHIFT(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .bus(bus2)
  );

  typedef struct {
    logic        s;
    logic        r;
    logic [15:0] d;
    logic        ack;
    logic        osend;
    logic [15:0] od;
    logic [2:0]  lvl;
  } vec_t;

  vec_t vecs[14];

`ifdef LH_STREAM_BUFFER_CLIP_EN
  localparam logic [15:0] EXP_NEG = 16'h0000;
`else
  localparam logic [15:0] EXP_NEG = 16'hFFFC;
`endif

  function automatic vec_t mk(bit s, bit r, int d, bit ack, bit os, int od, int lvl);
    vec_t v;
    v.s = s; v.r = r; v.d = 16'(d);
    v.ack = ack; v.osend = os; v.od = 16'(od); v.lvl = 3'(lvl);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Releases RESET just after a rising edge and checks ACK stays low for two cycles.
  task automatic guard_seq(input string tag);
    bus.In1_SEND = 1'b1;
    bus.In1_DATA = 16'h0055;
    bus.Out1_RDY = 1'b0;
    @(posedge CLK); #1 RESET = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check({tag, "_ack"}, 32'(bus.In1_ACK), (c == 2) ? 32'd1 : 32'd0);
      check({tag, "_osend"}, 32'(bus.Out1_SEND), 32'd0);
      if (c < 2) begin
        @(posedge CLK); #1;
      end
    end
    bus.In1_SEND = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tx, rx, cyc;

    vecs[0]  = mk(1, 0, 10, 1, 0,  0, 0);
    vecs[1]  = mk(0, 0,  0, 0, 0, 10, 1);
    vecs[2]  = mk(1, 0, 11, 1, 0, 10, 1);
    vecs[3]  = mk(1, 0, 12, 1, 0, 10, 2);
    vecs[4]  = mk(1, 0, 13, 1, 0, 10, 3);
    vecs[5]  = mk(1, 0, 14, 0, 0, 10, 4);
    vecs[6]  = mk(1, 0, 15, 0, 0, 10, 4);
    vecs[7]  = mk(1, 1, 16, 0, 1, 10, 4);
    vecs[8]  = mk(1, 1, 17, 1, 1, 11, 3);
    vecs[9]  = mk(0, 1,  0, 0, 1, 12, 3);
    vecs[10] = mk(0, 1,  0, 0, 1, 13, 2);
    vecs[11] = mk(1, 1, 18, 1, 1, 17, 1);
    vecs[12] = mk(0, 1,  0, 0, 1, 18, 1);
    vecs[13] = mk(0, 1,  0, 0, 0,  0, 0);

    bus.In1_DATA = '0;  bus.In1_SEND = 1'b1; bus.In1_COUNT = 16'd7;
    bus.Out1_RDY = 1'b0; bus.Out1_ACK = 1'b0;
    bus2.In1_DATA = '0; bus2.In1_SEND = 1'b0; bus2.In1_COUNT = 16'd0;
    bus2.Out1_RDY = 1'b0; bus2.Out1_ACK = 1'b0;

    #2;
    check("rst_ack",   32'(bus.In1_ACK),    32'd0);
    check("rst_osend", 32'(bus.Out1_SEND),  32'd0);
    check("rst_data",  32'(bus.Out1_DATA),  32'd0);
    check("rst_count", 32'(bus.Out1_COUNT), 32'd1);
    check("rst_level", 32'(bus.LEVEL),      32'd0);

    guard_seq("guard");

    for (int i = 0; i < 14; i++) begin
      bus.In1_SEND = vecs[i].s;
      bus.Out1_RDY = vecs[i].r;
      bus.In1_DATA = vecs[i].d;
      @(negedge CLK);
      check($sformatf("vec%0d_ack", i),   32'(bus.In1_ACK),   32'(vecs[i].ack));
      check($sformatf("vec%0d_osend", i), 32'(bus.Out1_SEND), 32'(vecs[i].osend));
      check($sformatf("vec%0d_odata", i), 32'(bus.Out1_DATA), 32'(vecs[i].od));
      check($sformatf("vec%0d_level", i), 32'(bus.LEVEL),     32'(vecs[i].lvl));
      @(posedge CLK); #1;
    end

    // Reset in the middle of a cycle with three tokens buffered.
    bus.In1_SEND = 1'b1;
    bus.Out1_RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.In1_DATA = 16'(20 + i);
      @(posedge CLK); #1;
    end
    bus.Out1_RDY = 1'b1;
    #1;
    check("pre_rst_level", 32'(bus.LEVEL),     32'd3);
    check("pre_rst_osend", 32'(bus.Out1_SEND), 32'd1);
    check("pre_rst_data",  32'(bus.Out1_DATA), 32'd20);
    RESET = 1'b1;
    #1;
    check("mid_rst_level", 32'(bus.LEVEL),     32'd0);
    check("mid_rst_osend", 32'(bus.Out1_SEND), 32'd0);
    check("mid_rst_ack",   32'(bus.In1_ACK),   32'd0);
    check("mid_rst_data",  32'(bus.Out1_DATA), 32'd0);
    guard_seq("reguard");
    @(negedge CLK);
    check("post_rst_level", 32'(bus.LEVEL),     32'd0);
    check("post_rst_data",  32'(bus.Out1_DATA), 32'd0);
    @(posedge CLK); #1;

    // Random handshakes, 1000 ordered tokens.
    tx = 0; rx = 0; cyc = 0;
    while (rx < 1000 && cyc < 20000) begin
      bus.In1_SEND = (tx < 1000) && ($urandom_range(0, 3) != 0);
      bus.In1_DATA = 16'(tx);
      bus.Out1_RDY = ($urandom_range(0, 2) != 0);
      @(negedge CLK);
      if (bus.In1_ACK) tx++;
      if (bus.Out1_SEND) begin
        check("rand_data", 32'(bus.Out1_DATA), 32'(rx));
        rx++;
      end
      check("rand_level_le_depth", 32'(bus.LEVEL <= 3'd4), 32'd1);
      @(posedge CLK); #1;
      cyc++;
    end
    check("rand_tokens_out", 32'(rx), 32'd1000);
    bus.In1_SEND = 1'b0;
    bus.Out1_RDY = 1'b0;

    // SHIFT=2 instance: sign-extended shift, clipped when enabled.
    bus2.In1_SEND = 1'b1;
    bus2.In1_DATA = 16'hFFF0;
    @(posedge CLK); #1;
    bus2.In1_DATA = 16'h0040;
    @(posedge CLK); #1;
    bus2.In1_SEND = 1'b0;
    bus2.Out1_RDY = 1'b1;
    @(negedge CLK);
    check("shift_neg",   32'(bus2.Out1_DATA), 32'(EXP_NEG));
    check("shift_level", 32'(bus2.LEVEL),     32'd2);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("shift_pos",   32'(bus2.Out1_DATA), 32'h0010);
    @(posedge CLK); #1;
    bus2.Out1_RDY = 1'b0;
    @(negedge CLK);
    check("shift_empty", 32'(bus2.LEVEL), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
